// File: rtl/spi_codec_pkg.sv
// spi_codec_pkg: phase and target encodings shared by the codec sequencer.
package spi_codec_pkg;
    typedef enum logic [2:0] {P_IDLE, P_SETUP, P_START, P_WAIT, P_HOLD, P_GAP} phase_t;
    typedef enum logic [1:0] {T_ADC, T_DAC, T_CFG} target_t;
    localparam logic [15:0] ADC_CMD_DEFAULT = 16'h0000;
endpackage

// File: rtl/spi_codec_sequencer_if.sv
// spi_codec_sequencer_if: shared SPI master handshake plus the three codec chip selects.
interface spi_codec_sequencer_if;
    logic spi_start;
    logic [15:0] spi_data_in;
    logic spi_busy;
    logic spi_new_data;
    logic [15:0] spi_data_out;
    logic cs_adc_n;
    logic cs_dac_n;
    logic cs_cfg_n;
    modport master (
        output spi_start, spi_data_in, cs_adc_n, cs_dac_n, cs_cfg_n,
        input spi_busy, spi_new_data, spi_data_out
    );
    modport slave (
        input spi_start, spi_data_in, cs_adc_n, cs_dac_n, cs_cfg_n,
        output spi_busy, spi_new_data, spi_data_out
    );
endinterface

// File: rtl/spi_txn_timer.sv
// spi_txn_timer: loadable saturating down-counter for setup, gap and watchdog intervals.
module spi_txn_timer #(
    parameter int W = 11
) (
    input logic clk,
    input logic rst,
    input logic load,
    input logic [W-1:0] load_val,
    output logic zero
);
    logic [W-1:0] cnt;
    always_ff @(posedge clk) begin
        if (rst) cnt <= '0;
        else if (load) cnt <= load_val;
        else if (cnt != '0) cnt <= cnt - 1'b1;
    end
    assign zero = cnt == '0;
endmodule

// File: rtl/spi_codec_sequencer.sv
// spi_codec_sequencer: runs ADC read then DAC write per audio tick on the shared SPI master,
// slotting codec config writes in between frames.
module spi_codec_sequencer
    import spi_codec_pkg::*;
#(
    parameter int SETUP_CYCLES = 2,
    parameter int GAP_CYCLES = 4,
    parameter int TIMEOUT = 1024,
    parameter logic [15:0] ADC_CMD = ADC_CMD_DEFAULT
) (
    input logic clk,
    input logic rst,
    input logic sample_tick,
    input logic [15:0] dac_data,
    input logic cfg_req,
    input logic [15:0] cfg_data,
    output logic cfg_ack,
    output logic [15:0] adc_sample,
    output logic adc_valid,
    output logic overrun,
    output logic timeout_err,
    spi_codec_sequencer_if.master bus
);
    localparam int TM0 = TIMEOUT > GAP_CYCLES ? TIMEOUT : GAP_CYCLES;
    localparam int TMAX = TM0 > SETUP_CYCLES ? TM0 : SETUP_CYCLES;
    localparam int TW = $clog2(TMAX + 1);
    phase_t phase;
    target_t target;
    logic tick_pending;
    logic [15:0] dac_hold;
    logic grant_adc, go_start, expire, t_load, t_zero;
    logic [TW-1:0] t_val;
    always_comb begin
        grant_adc = phase == P_IDLE && (tick_pending || sample_tick);
        go_start = phase == P_SETUP && t_zero && !bus.spi_busy;
        expire = phase == P_WAIT && !bus.spi_new_data && t_zero;
        t_load = phase == P_IDLE ? (grant_adc || cfg_req) :
                 phase == P_SETUP ? go_start :
                 phase == P_HOLD || expire || (phase == P_GAP && t_zero && target == T_ADC);
        t_val = go_start ? TW'(TIMEOUT - 1) :
                (phase == P_HOLD || expire) ? TW'(GAP_CYCLES - 1) : TW'(SETUP_CYCLES - 1);
    end
    spi_txn_timer #(.W(TW)) u_timer (
        .clk(clk),
        .rst(rst),
        .load(t_load),
        .load_val(t_val),
        .zero(t_zero)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            phase <= P_IDLE;
            target <= T_ADC;
            tick_pending <= 1'b0;
            dac_hold <= '0;
            adc_sample <= '0;
            adc_valid <= 1'b0;
            cfg_ack <= 1'b0;
            overrun <= 1'b0;
            timeout_err <= 1'b0;
            bus.spi_start <= 1'b0;
            bus.spi_data_in <= '0;
            bus.cs_adc_n <= 1'b1;
            bus.cs_dac_n <= 1'b1;
            bus.cs_cfg_n <= 1'b1;
        end else begin
            adc_valid <= 1'b0;
            cfg_ack <= 1'b0;
            timeout_err <= 1'b0;
            bus.spi_start <= 1'b0;
            overrun <= sample_tick && tick_pending;
            tick_pending <= !grant_adc && (tick_pending || sample_tick);
            if (sample_tick) dac_hold <= dac_data;
            case (phase)
                P_IDLE: begin
                    if (grant_adc) begin
                        phase <= P_SETUP;
                        target <= T_ADC;
                        bus.cs_adc_n <= 1'b0;
                        bus.spi_data_in <= ADC_CMD;
                    end else if (cfg_req) begin
                        phase <= P_SETUP;
                        target <= T_CFG;
                        bus.cs_cfg_n <= 1'b0;
                        bus.spi_data_in <= cfg_data;
                    end
                end
                P_SETUP: begin
                    if (go_start) begin
                        phase <= P_START;
                        bus.spi_start <= 1'b1;
                    end
                end
                P_START: phase <= P_WAIT;
                P_WAIT: begin
                    if (bus.spi_new_data) begin
                        phase <= P_HOLD;
                        if (target == T_ADC) begin
                            adc_sample <= bus.spi_data_out;
                            adc_valid <= 1'b1;
                        end
                        cfg_ack <= target == T_CFG;
                    end else if (t_zero) begin
                        // watchdog abort skips HOLD so no valid/ack is issued
                        phase <= P_GAP;
                        timeout_err <= 1'b1;
                        bus.cs_adc_n <= 1'b1;
                        bus.cs_dac_n <= 1'b1;
                        bus.cs_cfg_n <= 1'b1;
                    end
                end
                P_HOLD: begin
                    phase <= P_GAP;
                    bus.cs_adc_n <= 1'b1;
                    bus.cs_dac_n <= 1'b1;
                    bus.cs_cfg_n <= 1'b1;
                end
                P_GAP: begin
                    if (t_zero && target == T_ADC) begin
                        phase <= P_SETUP;
                        target <= T_DAC;
                        bus.cs_dac_n <= 1'b0;
                        bus.spi_data_in <= dac_hold;
                    end else if (t_zero) phase <= P_IDLE;
                end
                default: phase <= P_IDLE;
            endcase
        end
    end
endmodule

// File: doc/spi_codec_sequencer.md
Name: spi_codec_sequencer

Overview:
- Controller that sequences the shared 16-bit SPI master between the audio ADC, the audio DAC and the codec configuration path.
- On each audio sample tick it runs one ADC read, then one DAC write, driving the master's start/data_in and decoding busy/new_data/data_out.
- Configuration writes from the control block are serviced only between audio frames.
- Owns the three active-low chip selects, inter-transaction gaps, overrun detection and a transfer watchdog.

Parameters:
SETUP_CYCLES, 2, cycles CS is held low before spi_start (>=1)
GAP_CYCLES, 4, cycles all CS high between transactions (>=1)
TIMEOUT, 1024, max cycles from spi_start to spi_new_data before abort
ADC_CMD, 16'h0000, word shifted out during the ADC read

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
sample_tick  in  1  one-cycle audio frame strobe
dac_data  in  16  DAC sample, captured on accepted sample_tick
cfg_req  in  1  level request for a config write
cfg_data  in  16  config word, captured when the request is granted
cfg_ack  out  1  one-cycle pulse when the config transaction completes
adc_sample  out  16  last ADC word received
adc_valid  out  1  one-cycle pulse when adc_sample updates
overrun  out  1  one-cycle pulse: tick arrived while a tick was already pending
timeout_err  out  1  one-cycle pulse on watchdog abort
spi_start  out  1  to master start (one-cycle pulse)
spi_data_in  out  16  to master data_in
spi_busy  in  1  from master busy
spi_new_data  in  1  from master new_data
spi_data_out  in  16  from master data_out
cs_adc_n  out  1  ADC chip select
cs_dac_n  out  1  DAC chip select
cs_cfg_n  out  1  codec config chip select

Behaviour:
- Reset values:
  - All CS outputs 1.
  - spi_start, cfg_ack, adc_valid, overrun and timeout_err are 0.
  - adc_sample and spi_data_in are 16'h0.
  - State IDLE; tick_pending 0.
- Reset mid-transaction aborts immediately with no ack or valid pulse; CS goes high the cycle after rst is sampled.
- All outputs are registered.
- sample_tick:
  - Sets tick_pending and captures dac_data into dac_hold.
  - If tick_pending is already 1 in that cycle, overrun pulses, dac_hold is overwritten and only one frame is run.
  - tick_pending clears when the ADC SETUP phase is entered.
  - A tick during an active frame sets pending and runs a further frame afterwards.
- Arbitration in IDLE:
  - tick_pending takes priority over cfg_req.
  - A granted config transaction always runs to completion; a tick arriving during it waits.
- Per-transaction phases (target = ADC, DAC or CFG):
  - SETUP: target CS low, SETUP_CYCLES cycles. spi_data_in is loaded on entry: ADC_CMD, dac_hold, or cfg_data captured at grant.
  - START: spi_start=1 for exactly one cycle.
  - WAIT: hold until spi_new_data=1. The watchdog counts from START.
  - HOLD: one cycle, CS still low. On entry:
    - ADC: adc_sample <= spi_data_out and adc_valid pulses.
    - CFG: cfg_ack pulses.
  - GAP: all CS high for GAP_CYCLES cycles.
- Phase transitions:
  - ADC GAP goes to DAC SETUP (dac_hold is sent).
  - DAC GAP goes to IDLE.
  - CFG GAP goes to IDLE.
- Watchdog: if TIMEOUT cycles elapse in WAIT without spi_new_data:
  - timeout_err pulses and the current transaction goes to GAP.
  - No adc_valid or cfg_ack is issued.
  - After an ADC timeout the DAC write is still attempted.
- spi_busy:
  - Must be 0 before START is issued; START stalls while spi_busy=1 (SETUP is extended).
  - spi_new_data outside WAIT is ignored.
- Exactly one CS is low at any time, or none.

Decomposition:
- Shared package spi_codec_pkg:
  - Phase encoding (IDLE, SETUP, START, WAIT, HOLD, GAP).
  - Target encoding (ADC, DAC, CFG).
  - Default ADC_CMD constant.
- One sub-module, spi_txn_timer: the down-counter shared by SETUP, GAP and the watchdog, with a load value and a zero flag.

Test Plan:
- Single tick, dac_data=16'hA5C3, master model returns 16'h1234 → cs_adc_n low for the ADC transaction, then adc_sample=16'h1234 with one adc_valid pulse; after 4 gap cycles cs_dac_n goes low, spi_data_in=16'hA5C3 and one spi_start pulse is seen.
- cfg_req with cfg_data=16'h8042 in idle → cs_cfg_n low 2 cycles before spi_start; cfg_ack pulses once after new_data; all CS high for 4 cycles.
- cfg_req and sample_tick in the same cycle → ADC then DAC run first, cfg after; a tick during the cfg transfer is served after cfg_ack.
- Two ticks 3 cycles apart while idle-pending → one overrun pulse; a single frame sends the second dac_data.
- Master model never asserts new_data → timeout_err exactly 1024 cycles after spi_start, no adc_valid, DAC write still performed.
- rst asserted during DAC WAIT → next cycle all CS=1, no ack/valid pulses, IDLE; a subsequent tick runs a normal frame.
